// File: rtl/dealign.sv
// Dealign: 2-entry FIFO between an IN and an OUT stream that tags each word with iteration/run-end flags.
// Optional error detection for words offered outside RUN is built when DEALIGN_ERROR_CHECK_EN is defined.
module dealign #(
  parameter int NUM_INPUTS              = 8,
  parameter int DATA_WIDTH              = 8,
  parameter int LOG_MAX_ITERS           = 16,
  parameter int LOG_MAX_WRITES_PER_ITER = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               configure,
  input  logic [LOG_MAX_ITERS-1:0]           num_iters,
  input  logic [LOG_MAX_WRITES_PER_ITER-1:0] num_writes_per_iter,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]   data_in,
  input  logic                               valid_in,
  output logic                               avail_out,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0]   data_out,
  output logic                               valid_out,
  input  logic                               avail_in,
  output logic                               last_iter_out,
  output logic                               last_out,
  output logic                               done,
  output logic                               error
);
  localparam int W  = NUM_INPUTS*DATA_WIDTH;
  localparam int TW = LOG_MAX_ITERS + LOG_MAX_WRITES_PER_ITER;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                             r_state, w_next;
  logic [LOG_MAX_ITERS-1:0]           r_num_iters, r_iter_cnt;
  logic [LOG_MAX_WRITES_PER_ITER-1:0] r_num_wpi, r_word_cnt;
  logic [TW-1:0]                      r_total, r_accepted;
  logic [1:0][W-1:0]                  r_mem;
  logic [1:0]                         r_li_q, r_l_q;
  logic                               r_rd, r_wr;
  logic [1:0]                         r_count;

  logic w_push, w_pop, w_valid, w_li, w_l;

  assign w_valid = (r_count != 2'd0);
  assign w_push  = valid_in && avail_out;
  assign w_pop   = w_valid && avail_in;
  // Flags are decided at accept time so they travel with the word through the FIFO.
  assign w_li    = (r_word_cnt == r_num_wpi - 1'b1);
  assign w_l     = w_li && (r_iter_cnt == r_num_iters - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (configure)
      w_next = (num_iters == '0 || num_writes_per_iter == '0) ? S_DONE : S_RUN;
    else if (r_state == S_RUN && w_pop && r_l_q[r_rd])
      w_next = S_DONE;
  end

  always_comb begin
    avail_out     = (r_state == S_RUN) && (r_accepted < r_total) && (r_count < 2'd2);
    valid_out     = w_valid;
    data_out      = r_mem[r_rd];
    last_iter_out = w_valid && r_li_q[r_rd];
    last_out      = w_valid && r_l_q[r_rd];
    done          = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst || configure) begin
      r_iter_cnt  <= '0;
      r_word_cnt  <= '0;
      r_accepted  <= '0;
      r_mem       <= '0;
      r_li_q      <= '0;
      r_l_q       <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_count     <= 2'd0;
      r_num_iters <= rst ? '0 : num_iters;
      r_num_wpi   <= rst ? '0 : num_writes_per_iter;
      r_total     <= rst ? '0 : TW'(num_iters) * TW'(num_writes_per_iter);
    end else begin
      if (w_push) begin
        r_mem[r_wr]  <= data_in;
        r_li_q[r_wr] <= w_li;
        r_l_q[r_wr]  <= w_l;
        r_wr         <= ~r_wr;
        r_accepted   <= r_accepted + 1'b1;
        if (w_li) begin
          r_word_cnt <= '0;
          r_iter_cnt <= r_iter_cnt + 1'b1;
        end else begin
          r_word_cnt <= r_word_cnt + 1'b1;
        end
      end
      if (w_pop) r_rd <= ~r_rd;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef DEALIGN_ERROR_CHECK_EN
  logic r_error;
  always_ff @(posedge clk) begin
    if (rst || configure)                   r_error <= 1'b0;
    else if (valid_in && r_state != S_RUN)  r_error <= 1'b1;
  end
  assign error = r_error;
`else
  assign error = 1'b0;
`endif
endmodule

// File: tb/tb_dealign.sv
// Scoreboard bench for dealign: stimulus pushes expected words, a negedge monitor pops on each output transfer.
module tb_dealign;
  localparam int NI = 8, DW = 8, LI = 16, LW = 16, W = NI*DW;

  logic          clk = 1'b0;
  logic          rst, configure, valid_in, avail_in;
  logic [LI-1:0] num_iters;
  logic [LW-1:0] num_writes_per_iter;
  logic [W-1:0]  data_in, data_out;
  logic          avail_out, valid_out, last_iter_out, last_out, done, error;

  dealign #(.NUM_INPUTS(NI), .DATA_WIDTH(DW), .LOG_MAX_ITERS(LI), .LOG_MAX_WRITES_PER_ITER(LW)) dut (
    .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
    .num_writes_per_iter(num_writes_per_iter), .data_in(data_in), .valid_in(valid_in),
    .avail_out(avail_out), .data_out(data_out), .valid_out(valid_out), .avail_in(avail_in),
    .last_iter_out(last_iter_out), .last_out(last_out), .done(done), .error(error));

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] d; logic li; logic l; } exp_t;
  exp_t q[$];
  int n_checks = 0, n_errors = 0;

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Each lane gets a distinct value so lane reordering is visible.
  function automatic logic [W-1:0] mkw(logic [7:0] b);
    logic [W-1:0] r;
    for (int i = 0; i < NI; i++) r[i*DW +: DW] = b ^ 8'(i << 4);
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid_out && avail_in) begin
      if (q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL out_unexpected: got %h, scoreboard empty", data_out);
      end else begin
        e = q.pop_front();
        chk("out_data", data_out, e.d);
        chk("out_last_iter", W'(last_iter_out), W'(e.li));
        chk("out_last", W'(last_out), W'(e.l));
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_cfg(int it, int wp);
    configure = 1'b1; num_iters = LI'(it); num_writes_per_iter = LW'(wp);
    cyc();
    configure = 1'b0;
    q.delete();
  endtask

  task automatic send(logic [7:0] b, logic li, logic l);
    exp_t e;
    data_in = mkw(b); valid_in = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (avail_out) begin
        e.d = mkw(b); e.li = li; e.l = l;
        q.push_back(e);
        cyc();
        return;
      end
    end
    n_checks++; n_errors++;
    $display("FAIL send_timeout: word %h not accepted, required acceptance within 50 cycles", b);
    cyc();
  endtask

  task automatic wait_done();
    for (int k = 0; k < 50 && !done; k++) cyc();
    @(negedge clk);
    chk("done_after_run", W'(done), W'(1));
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; configure = 1'b0; valid_in = 1'b0; avail_in = 1'b0;
    num_iters = '0; num_writes_per_iter = '0; data_in = '0;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_valid_out", W'(valid_out), '0);
    chk("rst_avail_out", W'(avail_out), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_error", W'(error), '0);
    chk("rst_data_out", data_out, '0);
    chk("rst_last", W'({last_iter_out, last_out}), '0);
    cyc();
    rst = 1'b0;
    cyc();

    // Basic run: 2 iterations x 3 words, downstream always ready.
    avail_in = 1'b1;
    do_cfg(2, 3);
    send(8'h01, 1'b0, 1'b0);
    valid_in = 1'b0;
    @(negedge clk);
    chk("lat_valid", W'(valid_out), W'(1));
    chk("lat_data", data_out, mkw(8'h01));
    cyc();
    for (int k = 1; k < 6; k++) send(8'(k + 1), (k % 3) == 2, k == 5);
    valid_in = 1'b0;
    @(negedge clk);
    chk("done_before_last_xfer", W'(done), '0);
    cyc();
    @(negedge clk);
    chk("done_after_last_xfer", W'(done), W'(1));
    chk("done_avail_out", W'(avail_out), '0);
    cyc();

    // Backpressure: two words fill the FIFO, output holds the first.
    avail_in = 1'b0;
    do_cfg(2, 3);
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    data_in = mkw(8'h03); valid_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_avail_out", W'(avail_out), '0);
      chk("bp_valid_out", W'(valid_out), W'(1));
      chk("bp_data_hold", data_out, mkw(8'h01));
      cyc();
    end
    avail_in = 1'b1;
    for (int k = 2; k < 6; k++) send(8'(k + 1), (k % 3) == 2, k == 5);
    valid_in = 1'b0;
    wait_done();

    // Empty run: zero iterations goes straight to DONE.
    do_cfg(0, 3);
    data_in = mkw(8'hAA); valid_in = 1'b1;
    @(negedge clk);
    chk("zero_done", W'(done), W'(1));
    chk("zero_avail_out", W'(avail_out), '0);
    chk("zero_error_first", W'(error), '0);
    cyc();
    @(negedge clk);
    chk("zero_avail_out2", W'(avail_out), '0);
`ifdef DEALIGN_ERROR_CHECK_EN
    chk("done_error", W'(error), W'(1));
`else
    chk("done_error", W'(error), '0);
`endif
    cyc();
    valid_in = 1'b0;

    // Reconfigure mid-run with one word buffered.
    avail_in = 1'b1;
    do_cfg(2, 3);
    @(negedge clk);
    chk("cfg_clears_error", W'(error), '0);
    cyc();
    send(8'h11, 1'b0, 1'b0);
    valid_in = 1'b0;
    cyc();
    avail_in = 1'b0;
    send(8'h12, 1'b0, 1'b0);
    valid_in = 1'b0;
    @(negedge clk);
    chk("pre_flush_valid", W'(valid_out), W'(1));
    cyc();
    do_cfg(2, 3);
    @(negedge clk);
    chk("flush_valid_out", W'(valid_out), '0);
    chk("flush_avail_out", W'(avail_out), W'(1));
    chk("flush_done", W'(done), '0);
    cyc();
    avail_in = 1'b1;
    for (int k = 0; k < 6; k++) send(8'(8'h21 + k), (k % 3) == 2, k == 5);
    valid_in = 1'b0;
    wait_done();

    // Reset together with configure mid-run.
    avail_in = 1'b0;
    do_cfg(2, 3);
    send(8'h31, 1'b0, 1'b0);
    send(8'h32, 1'b0, 1'b0);
    valid_in = 1'b0;
    rst = 1'b1; configure = 1'b1; num_iters = 16'd2; num_writes_per_iter = 16'd3;
    cyc();
    configure = 1'b0;
    @(negedge clk);
    chk("rstcfg_valid_out", W'(valid_out), '0);
    chk("rstcfg_avail_out", W'(avail_out), '0);
    chk("rstcfg_done_error", W'({done, error}), '0);
    chk("rstcfg_last", W'({last_iter_out, last_out}), '0);
    chk("rstcfg_data_out", data_out, '0);
    cyc();
    rst = 1'b0;
    q.delete();
    cyc();
    @(negedge clk);
    chk("idle_avail_out", W'(avail_out), '0);
    chk("idle_done", W'(done), '0);
    cyc();

    chk("scoreboard_empty", W'(q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dealign.md
DEALIGN -- requirements
Module: dealign

Interface
REQ-001 Parameter NUM_INPUTS, 8, number of lanes per word (output lanes == input lanes).
REQ-002 Parameter DATA_WIDTH, 8, bits per lane.
REQ-003 Parameter LOG_MAX_ITERS, 16, width of num_iters and the iteration counter.
REQ-004 Parameter LOG_MAX_WRITES_PER_ITER, 16, width of num_writes_per_iter and the word-in-iteration counter.
REQ-005 clk  input  1  sole clock; all logic on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 configure  input  1  one-cycle pulse; loads num_iters and num_writes_per_iter, then starts a run.
REQ-008 num_iters  input  LOG_MAX_ITERS  iterations per run; sampled only on configure.
REQ-009 num_writes_per_iter  input  LOG_MAX_WRITES_PER_ITER  words per iteration; sampled only on configure.
REQ-010 data_in  input  NUM_INPUTS*DATA_WIDTH  IN interface data.
REQ-011 valid_in  input  1  IN interface valid.
REQ-012 avail_out  output  1  IN interface avail; the block can accept a word this cycle.
REQ-013 data_out  output  NUM_INPUTS*DATA_WIDTH  OUT interface data.
REQ-014 valid_out  output  1  OUT interface valid.
REQ-015 avail_in  input  1  OUT interface avail from the downstream writer.
REQ-016 last_iter_out  output  1  data_out is the last word of its iteration.
REQ-017 last_out  output  1  data_out is the last word of the run.
REQ-018 done  output  1  run complete, level, held until the next configure.
REQ-019 error  output  1  sticky protocol error flag (see Configuration).

Function
REQ-020 An input transfer occurs when valid_in && avail_out; an output transfer occurs when valid_out && avail_in.
REQ-021 States are IDLE, RUN and DONE; after reset the state is IDLE.
REQ-022 configure moves any state to RUN, clears both counters and the buffer, and takes priority over every other event in the same cycle, including an in-flight transfer, which is discarded.
REQ-023 If configure arrives with num_iters==0 or num_writes_per_iter==0, the next state is DONE and no word is accepted.
REQ-024 The buffer is a 2-entry FIFO; words leave in arrival order, with data unchanged and lanes in unchanged order.
REQ-025 avail_out = (state==RUN) && (accepted words < num_iters*num_writes_per_iter) && (occupancy < 2).
- Computed from registered state only; no combinational path from avail_in.
REQ-026 A word accepted in cycle N is presented on data_out with valid_out=1 in cycle N+1 at the earliest, i.e. 1-cycle latency.
REQ-027 valid_out = occupancy > 0.
- data_out, last_iter_out and last_out are held stable while valid_out && !avail_in.
REQ-028 Accept-side counters:
- The word counter increments per accepted word.
- It wraps to 0 at num_writes_per_iter-1, and the iteration counter increments at that point.
- Flags are computed at accept time and stored with the word.
REQ-029 last_iter_out=1 for the word whose word counter equals num_writes_per_iter-1.
- last_out=1 for the word that is also in iteration num_iters-1.
REQ-030 Transition RUN->DONE occurs in the cycle after the output transfer of the word with last_out=1.
- done=1 from that cycle.
REQ-031 Simultaneous accept and emit with occupancy 2 is not possible (avail_out=0).
- With occupancy 1, simultaneous accept and emit leaves occupancy at 1.
REQ-032 Counter arithmetic is unsigned.
- The run total is computed as num_iters*num_writes_per_iter in LOG_MAX_ITERS+LOG_MAX_WRITES_PER_ITER bits without overflow.

Reset
REQ-033 While rst=1, at the clock edge:
- state=IDLE, counters=0, buffer empty.
- Outputs: valid_out=0, avail_out=0, last_iter_out=0, last_out=0, done=0, error=0.
- data_out=0.
REQ-034 rst asserted mid-run abandons the run and discards buffered words.
- rst has priority over configure.

Configuration
REQ-035 The macro DEALIGN_ERROR_CHECK_EN controls error detection.
- When defined, error is set to 1 in any cycle where valid_in=1 while state is IDLE or DONE; the offending word is dropped.
- error stays 1 until rst or configure.
REQ-036 When DEALIGN_ERROR_CHECK_EN is not defined, error is constant 0 and no detection logic is built.
- Words offered in IDLE or DONE are still dropped silently.

Verification
REQ-037 configure with num_iters=2, num_writes_per_iter=3; 6 words 0x01..0x06 with avail_in=1 -> outputs 0x01..0x06 at 1-cycle latency, last_iter_out on 0x03 and 0x06, last_out on 0x06, done=1 one cycle after 0x06 transfers.
REQ-038 Same config, avail_in=0 for 5 cycles, valid_in=1 -> exactly 2 words accepted, then avail_out=0; data_out stays 0x01; releasing avail_in drains the words in order.
REQ-039 configure with num_iters=0 -> done=1 next cycle, avail_out never 1; with DEALIGN_ERROR_CHECK_EN defined, valid_in=1 in DONE -> error=1 next cycle.
REQ-040 configure pulsed after 2 of 6 words with 1 word buffered -> buffer flushed, valid_out=0, counters restart, and the next 6 words complete a fresh run.
REQ-041 rst asserted in the same cycle as configure mid-run -> all outputs at reset values next cycle, state IDLE.
